// File: rtl/arb_pkg.sv
// Shared types and limits for the unified instruction/data memory arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef enum logic {
        SRC_IF = 1'b0,
        SRC_D  = 1'b1
    } src_e;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 15;
    localparam int CNT_W       = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the port
// that did not win last time. No grant at all while enable is low.
module rr_arb2
    import arb_pkg::*;
(
    input  logic req_if,
    input  logic req_d,
    input  src_e last_src,
    input  logic enable,
    output logic gnt_if,
    output logic gnt_d
);

    // Pick at most one winner per cycle
    always_comb begin
        gnt_if = 1'b0;
        gnt_d  = 1'b0;
        if (enable) begin
            if (req_if && req_d) begin
                if (last_src == SRC_IF) begin
                    gnt_d = 1'b1;
                end else begin
                    gnt_if = 1'b1;
                end
            end else begin
                gnt_if = req_if;
                gnt_d  = req_d;
            end
        end else begin
            gnt_if = 1'b0;
            gnt_d  = 1'b0;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serializes instruction-fetch and data traffic onto one fixed-latency RAM,
// one transaction in flight, with req/gnt/rvalid handshakes on both sides.
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int ADDR_W  = 30
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic [3:0]        d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);

    if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_bad_mem_lat
        $error("mem_arbiter: MEM_LAT must be within 1..15");
    end

    state_e           state_r;
    src_e             src_r;
    src_e             last_src_r;
    logic             armed_r;
    logic [3:0]       we_r;
    logic [CNT_W-1:0] cnt_r;
    logic             grant_ok_s;

    // armed_r keeps grants off for the first cycle after reset release
    assign grant_ok_s = rst_n && armed_r && (state_r == IDLE || state_r == RESP);

    rr_arb2 u_rr_arb2 (
        .req_if   (if_req),
        .req_d    (d_req),
        .last_src (last_src_r),
        .enable   (grant_ok_s),
        .gnt_if   (if_gnt),
        .gnt_d    (d_gnt)
    );

    // Transaction sequencer; every output apart from the grants is registered here
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            src_r      <= SRC_IF;
            last_src_r <= SRC_D;
            armed_r    <= 1'b0;
            we_r       <= 4'd0;
            cnt_r      <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 4'd0;
            mem_addr   <= '0;
            mem_wdata  <= 32'd0;
            if_rvalid  <= 1'b0;
            if_rdata   <= 32'd0;
            d_rvalid   <= 1'b0;
            d_rdata    <= 32'd0;
            busy       <= 1'b0;
        end else begin
            armed_r   <= 1'b1;
            mem_en    <= 1'b0;
            mem_we    <= 4'd0;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            case (state_r)
                IDLE, RESP: begin
                    if (if_gnt || d_gnt) begin
                        src_r      <= d_gnt ? SRC_D : SRC_IF;
                        last_src_r <= d_gnt ? SRC_D : SRC_IF;
                        we_r       <= d_gnt ? d_we : 4'd0;
                        mem_en     <= 1'b1;
                        mem_we     <= d_gnt ? d_we : 4'd0;
                        mem_addr   <= d_gnt ? d_addr : if_addr;
                        mem_wdata  <= d_gnt ? d_wdata : 32'd0;
                        busy       <= 1'b1;
                        state_r    <= ISSUE;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    cnt_r   <= CNT_W'(MEM_LAT);
                    busy    <= 1'b1;
                    state_r <= WAIT;
                end
                WAIT: begin
                    busy <= 1'b1;
                    if (cnt_r == 4'd1) begin
                        // Writes acknowledge with zero data whatever the RAM returns
                        if (src_r == SRC_D) begin
                            d_rvalid <= 1'b1;
                            d_rdata  <= (we_r != 4'd0) ? 32'd0 : mem_rdata;
                        end else begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= mem_rdata;
                        end
                        state_r <= RESP;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench: directed vector table, handshake corner sequences and a
// randomized run against a transaction-timing reference model.
module tb_mem_arbiter;

    localparam int LAT = 3;
    localparam int AW  = 30;

    logic          clk = 1'b0;
    logic          rst_n, if_req, d_req;
    logic [AW-1:0] if_addr, d_addr, mem_addr;
    logic [3:0]    d_we, mem_we;
    logic [31:0]   d_wdata, mem_wdata, mem_rdata, if_rdata, d_rdata;
    logic          if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, busy;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_LAT(LAT), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    typedef struct packed {
        logic        if_gnt, d_gnt, mem_en;
        logic [3:0]  mem_we;
        logic [29:0] mem_addr;
        logic [31:0] mem_wdata;
        logic        if_rvalid;
        logic [31:0] if_rdata;
        logic        d_rvalid;
        logic [31:0] d_rdata;
        logic        busy;
    } outs_t;

    typedef struct {
        logic        if_req;
        logic [29:0] if_addr;
        logic        d_req;
        logic [3:0]  d_we;
        logic [29:0] d_addr;
        logic [31:0] d_wdata;
        outs_t       exp;
    } vec_t;

    function automatic logic [31:0] memfn(input logic [29:0] a);
        if (a == 30'h10) return 32'hDEADBEEF;
        return {a, 2'b01} ^ 32'hA5A5_0F0F;
    endfunction

    // RAM model: data for the mem_en cycle appears LAT cycles later, noise otherwise
    logic        pipe_en   [LAT];
    logic [29:0] pipe_addr [LAT];
    logic [31:0] noise;
    always @(posedge clk) begin
        pipe_en[0]   <= mem_en;
        pipe_addr[0] <= mem_addr;
        for (int k = 1; k < LAT; k++) begin
            pipe_en[k]   <= pipe_en[k-1];
            pipe_addr[k] <= pipe_addr[k-1];
        end
        noise <= $urandom;
    end
    assign mem_rdata = pipe_en[LAT-1] ? memfn(pipe_addr[LAT-1]) : noise;

    int          n_cmp = 0, n_bad = 0;
    int          cyc = 0, free_at = 0, cur_issue = 0, cur_resp = 0;
    bit          last_d = 1'b1, cur_v = 1'b0, cur_d = 1'b0;
    logic [29:0] cur_addr;
    logic [3:0]  cur_we;
    logic [31:0] cur_wdata;
    logic [31:0] e_if_rd = 32'd0, e_d_rd = 32'd0;
    outs_t       s, e;

    task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic checki(input string name, input int act, input int exp);
        check(name, 136'(act), 136'(exp));
    endtask

    // One clock cycle: sample at negedge, predict from transaction timing, compare
    task automatic tick();
        bit gnt_any, pick_d;
        @(negedge clk);
        s = {if_gnt, d_gnt, mem_en, mem_we, mem_addr, mem_wdata,
             if_rvalid, if_rdata, d_rvalid, d_rdata, busy};
        e = '0;
        if (cur_v && cyc == cur_issue) begin
            e.mem_en    = 1'b1;
            e.mem_we    = cur_we;
            e.mem_addr  = cur_addr;
            e.mem_wdata = cur_wdata;
        end
        if (cur_v && cyc == cur_resp) begin
            if (cur_d) begin
                e.d_rvalid = 1'b1;
                e_d_rd = (cur_we != 4'd0) ? 32'd0 : memfn(cur_addr);
            end else begin
                e.if_rvalid = 1'b1;
                e_if_rd = memfn(cur_addr);
            end
        end
        e.if_rdata = e_if_rd;
        e.d_rdata  = e_d_rd;
        e.busy     = cur_v && cyc >= cur_issue && cyc <= cur_resp;
        gnt_any = rst_n && cyc >= free_at && (if_req || d_req);
        pick_d  = d_req && !(if_req && last_d);
        e.if_gnt = gnt_any && !pick_d;
        e.d_gnt  = gnt_any && pick_d;
        check("model", s, e);
        if (!rst_n) begin
            cur_v = 1'b0; e_if_rd = 32'd0; e_d_rd = 32'd0;
            last_d = 1'b1; free_at = cyc + 2;
        end else if (gnt_any) begin
            cur_v = 1'b1; cur_d = pick_d; last_d = pick_d;
            cur_issue = cyc + 1; cur_resp = cyc + 2 + LAT; free_at = cur_resp;
            cur_addr  = pick_d ? d_addr : if_addr;
            cur_we    = pick_d ? d_we : 4'd0;
            cur_wdata = pick_d ? d_wdata : 32'd0;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_wait();
        if_req = 1'b0; d_req = 1'b0;
        repeat (LAT + 4) tick();
    endtask

    vec_t        tbl [14];
    int          gcyc [4];
    bit          gsrc [4];
    logic [29:0] aq [$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int ng, coinc, nd, nmem, ndv, nrv, rs, lastg;
        rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0; if_addr = '0;
        d_addr = '0; d_we = 4'd0; d_wdata = 32'd0;
        @(posedge clk);
        #1;
        repeat (2) tick();
        check("reset", s, 136'd0);
        rst_n = 1'b1; if_req = 1'b1; if_addr = 30'h10;
        tick();
        check("release", s, 136'd0);

        for (int i = 0; i < 14; i++) tbl[i] = '{default: '0};
        tbl[0].if_req = 1'b1; tbl[0].if_addr = 30'h10; tbl[0].exp.if_gnt = 1'b1;
        tbl[1].exp.mem_en = 1'b1; tbl[1].exp.mem_addr = 30'h10;
        for (int i = 1; i <= 5; i++) tbl[i].exp.busy = 1'b1;
        tbl[5].exp.if_rvalid = 1'b1;
        for (int i = 5; i < 14; i++) tbl[i].exp.if_rdata = 32'hDEADBEEF;
        tbl[7].d_req = 1'b1; tbl[7].d_we = 4'b0011; tbl[7].d_addr = 30'h20;
        tbl[7].d_wdata = 32'h1234ABCD; tbl[7].exp.d_gnt = 1'b1;
        tbl[8].exp.mem_en = 1'b1; tbl[8].exp.mem_we = 4'b0011;
        tbl[8].exp.mem_addr = 30'h20; tbl[8].exp.mem_wdata = 32'h1234ABCD;
        for (int i = 8; i <= 12; i++) tbl[i].exp.busy = 1'b1;
        tbl[12].exp.d_rvalid = 1'b1;

        for (int i = 0; i < 14; i++) begin
            if_req = tbl[i].if_req; if_addr = tbl[i].if_addr;
            d_req = tbl[i].d_req; d_we = tbl[i].d_we;
            d_addr = tbl[i].d_addr; d_wdata = tbl[i].d_wdata;
            tick();
            check($sformatf("tbl%0d", i), s, tbl[i].exp);
        end

        // Both ports hold requests: expect IF, D, IF, D back to back
        if_req = 1'b1; if_addr = 30'h40; d_req = 1'b1; d_we = 4'd0; d_addr = 30'h50;
        ng = 0; coinc = 0;
        for (int k = 0; k < 60 && ng < 4; k++) begin
            tick();
            if (s.if_gnt || s.d_gnt) begin
                gcyc[ng] = cyc - 1; gsrc[ng] = s.d_gnt;
                if (ng > 0 && (s.if_rvalid || s.d_rvalid)) coinc++;
                ng++;
            end
        end
        checki("rr_count", ng, 4);
        for (int j = 0; j < ng; j++) checki("rr_src", int'(gsrc[j]), j % 2);
        for (int j = 1; j < ng; j++) checki("rr_gap", gcyc[j] - gcyc[j-1], LAT + 2);
        checki("rr_coinc", coinc, 3);
        idle_wait();

        // A data request that comes and goes while IF waits must leave no trace
        if_req = 1'b1; if_addr = 30'h77;
        tick();
        checki("wd_if_gnt", int'(s.if_gnt), 1);
        if_req = 1'b0;
        repeat (2) tick();
        d_req = 1'b1; d_addr = 30'h99; d_we = 4'd0;
        tick();
        nd = int'(s.d_gnt); nmem = int'(s.mem_en); ndv = 0;
        d_req = 1'b0;
        repeat (LAT + 4) begin
            tick();
            nd += int'(s.d_gnt); nmem += int'(s.mem_en); ndv += int'(s.d_rvalid);
        end
        checki("wd_d_gnt", nd, 0);
        checki("wd_mem_en", nmem, 0);
        checki("wd_d_rvalid", ndv, 0);

        // Reset during WAIT drops the access; a later fetch behaves normally
        if_req = 1'b1; if_addr = 30'h10;
        tick();
        if_req = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_mid_zero", s, 136'd0);
        nrv = 0;
        repeat (LAT + 3) begin
            tick();
            nrv += int'(s.if_rvalid) + int'(s.d_rvalid);
        end
        checki("rst_mid_no_rvalid", nrv, 0);
        if_req = 1'b1; if_addr = 30'h10;
        tick();
        checki("rst_regnt", int'(s.if_gnt), 1);
        if_req = 1'b0;
        repeat (LAT + 1) tick();
        tick();
        check("rst_resp", {s.if_rvalid, s.if_rdata}, {1'b1, 32'hDEADBEEF});
        idle_wait();

        // Back-to-back fetches on IF alone, address advancing after each grant
        if_req = 1'b1; if_addr = 30'h100; rs = 0; lastg = -1;
        for (int k = 0; k < 4 * (LAT + 2) + 6 && rs < 3; k++) begin
            tick();
            if (s.if_rvalid) begin
                rs++;
                if (aq.size() > 0) check("b2b_data", 136'(s.if_rdata), 136'(memfn(aq.pop_front())));
                else checki("b2b_unexpected_rvalid", 1, 0);
            end
            if (s.if_gnt) begin
                if (lastg >= 0) checki("b2b_gap", cyc - 1 - lastg, LAT + 2);
                lastg = cyc - 1;
                aq.push_back(if_addr);
                if_addr = if_addr + 30'd1;
            end
        end
        checki("b2b_count", rs, 3);
        idle_wait();

        // Randomized traffic with withdrawals and occasional resets
        for (int k = 0; k < 3000; k++) begin
            rst_n = ($urandom_range(599) != 0);
            if (if_req && !s.if_gnt) begin
                if ($urandom_range(9) == 0) if_req = 1'b0;
            end else begin
                if_req  = ($urandom_range(9) < 5);
                if_addr = 30'($urandom);
            end
            if (d_req && !s.d_gnt) begin
                if ($urandom_range(9) == 0) d_req = 1'b0;
            end else begin
                d_req   = ($urandom_range(9) < 5);
                d_we    = ($urandom_range(1) == 1) ? 4'($urandom) : 4'd0;
                d_addr  = 30'($urandom);
                d_wdata = $urandom;
            end
            tick();
        end
        rst_n = 1'b1;
        idle_wait();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
